// File: rtl/seg7_dig2_reader_pkg.sv
// Shared 7-segment definitions for the 2-digit encoder/reader pair.
package seg7_dig2_reader_pkg;

    // Active-low segment drive levels.
    localparam logic SEG_ON  = 1'b0;
    localparam logic SEG_OFF = 1'b1;

    // Digit patterns [6:0] = {mid, top-left, bottom-left, bottom, bottom-right, top-right, top}.
    localparam logic [6:0] SEG_D0 = 7'b1000000;
    localparam logic [6:0] SEG_D1 = 7'b1111001;
    localparam logic [6:0] SEG_D2 = 7'b0100100;
    localparam logic [6:0] SEG_D3 = 7'b0110000;
    localparam logic [6:0] SEG_D4 = 7'b0011001;
    localparam logic [6:0] SEG_D5 = 7'b0010010;
    localparam logic [6:0] SEG_D6 = 7'b0000010;
    localparam logic [6:0] SEG_D7 = 7'b1111000;
    localparam logic [6:0] SEG_D8 = 7'b0000000;
    localparam logic [6:0] SEG_D9 = 7'b0011000;

    // Reader FSM states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_CONV,
        ST_DONE
    } state_t;

    // Digit -> pattern, for encoders sharing these constants.
    function automatic logic [6:0] digit_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = SEG_D0;
            4'd1:    p = SEG_D1;
            4'd2:    p = SEG_D2;
            4'd3:    p = SEG_D3;
            4'd4:    p = SEG_D4;
            4'd5:    p = SEG_D5;
            4'd6:    p = SEG_D6;
            4'd7:    p = SEG_D7;
            4'd8:    p = SEG_D8;
            4'd9:    p = SEG_D9;
            default: p = {7{SEG_OFF}};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg7_dig2_reader_pat2bcd.sv
// Combinational active-low 7-segment pattern -> {legal, bcd} decoder.
module seg7_pat2bcd
    import seg7_dig2_reader_pkg::*;
(
    input  logic [6:0] pat,
    output logic       legal,
    output logic [3:0] bcd
);

    // Exact match against the ten digit patterns; anything else is illegal.
    always_comb begin
        legal = 1'b1;
        bcd   = '0;
        case (pat)
            SEG_D0:  bcd = 4'd0;
            SEG_D1:  bcd = 4'd1;
            SEG_D2:  bcd = 4'd2;
            SEG_D3:  bcd = 4'd3;
            SEG_D4:  bcd = 4'd4;
            SEG_D5:  bcd = 4'd5;
            SEG_D6:  bcd = 4'd6;
            SEG_D7:  bcd = 4'd7;
            SEG_D8:  bcd = 4'd8;
            SEG_D9:  bcd = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_dig2_reader.sv
// Two-digit 7-segment reader: captures a pattern pair, validates it and
// converts the BCD value to binary with a sequential reverse double-dabble.
module seg7_dig2_reader
    import seg7_dig2_reader_pkg::*;
#(
    parameter int unsigned OUT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       disp2,
    input  logic [6:0]       disp1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] bin_out,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned CNT_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [6:0]  MAX_VAL = 7'((1 << OUT_W) - 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(OUT_W - 1);

    state_t state_q, state_d;

    logic [6:0]       cap2_q, cap1_q;
    logic [7:0]       bcd_q;
    logic [OUT_W-1:0] bin_q;
    logic [CNT_W-1:0] cnt_q;

    logic             legal_tens, legal_ones;
    logic [3:0]       tens, ones;
    logic [6:0]       value;
    logic             dec_ok;
    logic             accept;
    logic             conv_last;
    logic [OUT_W+7:0] shifted;
    logic [7:0]       bcd_step;
    logic [OUT_W-1:0] bin_step;

    seg7_pat2bcd u_pat_tens (
        .pat   (cap2_q),
        .legal (legal_tens),
        .bcd   (tens)
    );

    seg7_pat2bcd u_pat_ones (
        .pat   (cap1_q),
        .legal (legal_ones),
        .bcd   (ones)
    );

    // Handshake, range check and iteration bookkeeping.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !reset;
        out_valid = (state_q == ST_DONE);
        accept    = in_valid && in_ready;
        value     = 7'(tens) * 7'd10 + 7'(ones);
        dec_ok    = legal_tens && legal_ones && (value <= MAX_VAL);
        conv_last = (cnt_q == LAST_ITER);
    end

    // One reverse double-dabble step: shift {bcd,bin} right, then fix nibbles >= 8.
    always_comb begin
        shifted  = {bcd_q, bin_q} >> 1;
        bcd_step = shifted[OUT_W+7:OUT_W];
        bin_step = shifted[OUT_W-1:0];
        if (bcd_step[7:4] >= 4'd8) bcd_step[7:4] = bcd_step[7:4] - 4'd3;
        if (bcd_step[3:0] >= 4'd8) bcd_step[3:0] = bcd_step[3:0] - 4'd3;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept)    state_d = ST_DECODE;
            ST_DECODE: state_d = dec_ok ? ST_CONV : ST_DONE;
            ST_CONV:   if (conv_last) state_d = ST_DONE;
            ST_DONE:   if (out_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Capture, conversion datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap2_q  <= '0;
            cap1_q  <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cap2_q <= disp2;
                        cap1_q <= disp1;
                    end
                end
                ST_DECODE: begin
                    if (!dec_ok) begin
                        err     <= 1'b1;
                        bin_out <= '0;
                    end else begin
                        bcd_q <= {tens, ones};
                        bin_q <= '0;
                        cnt_q <= '0;
                    end
                end
                ST_CONV: begin
                    bcd_q <= bcd_step;
                    bin_q <= bin_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Final step's result goes straight to the output so DONE follows immediately.
                    if (conv_last) begin
                        bin_out <= bin_step;
                        err     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
